// File: rtl/register_file_pkg.sv
// Shared constants and ALU mode codes for the ARMv8 datapath slice.
// Used by the register file, ALU, control and datapath top.
package register_file_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_COUNT  = 32;
    localparam logic [4:0] XZR_INDEX = 5'd31;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_LSL   = 4'b0011,
        ALU_LSR   = 4'b0100,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_mode_t;

    // Reference ALU behaviour; shift amount uses the low 6 bits of B.
    function automatic logic [DATA_WIDTH-1:0] alu_ref(
        input alu_mode_t             mode,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (mode)
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_ADD:   r = a + b;
            ALU_LSL:   r = a << b[5:0];
            ALU_LSR:   r = a >> b[5:0];
            ALU_SUB:   r = a - b;
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: XZR forced to zero, optional same-cycle
// forwarding of the write-back value.
module regfile_read_port #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0] sel_i,
    input  logic [DATA_WIDTH-1:0] stored_i,
    input  logic [ADDR_WIDTH-1:0] wr_sel_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_en_i,
    input  logic                  rst_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    import register_file_pkg::*;

    logic sel_is_xzr;
    logic fwd_hit;

    assign sel_is_xzr = (sel_i == ADDR_WIDTH'(XZR_INDEX));
    // A write to XZR never forwards, and a reset cycle drops the write.
    assign fwd_hit = BYPASS && !rst_i && wr_en_i && (wr_sel_i == sel_i) && !sel_is_xzr;

    always_comb begin
        data_o = stored_i;
        if (sel_is_xzr) begin
            data_o = '0;
        end else if (fwd_hit) begin
            data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit ARMv8 general-purpose register file: two combinational read
// ports, one synchronous write port, X31 reads as zero (XZR).
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadSelect1,
    input  logic [ADDR_WIDTH-1:0] ReadSelect2,
    input  logic [ADDR_WIDTH-1:0] WriteSelect,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);
    import register_file_pkg::*;

    // The top index is XZR and has no storage.
    localparam int NUM_STORED = (1 << ADDR_WIDTH) - 1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_STORED];
    logic [DATA_WIDTH-1:0] regs_d [NUM_STORED];
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    always_comb begin
        for (int i = 0; i < NUM_STORED; i++) begin
            regs_d[i] = regs_q[i];
            if (RegWrite && (WriteSelect == ADDR_WIDTH'(i))) begin
                regs_d[i] = WriteData;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_STORED; i++) begin
            if (Reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int i = 0; i < NUM_STORED; i++) begin
            if (ReadSelect1 == ADDR_WIDTH'(i)) stored1 = regs_q[i];
            if (ReadSelect2 == ADDR_WIDTH'(i)) stored2 = regs_q[i];
        end
    end

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_port1 (
        .sel_i    (ReadSelect1),
        .stored_i (stored1),
        .wr_sel_i (WriteSelect),
        .wr_data_i(WriteData),
        .wr_en_i  (RegWrite),
        .rst_i    (Reset),
        .data_o   (ReadData1)
    );

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_port2 (
        .sel_i    (ReadSelect2),
        .stored_i (stored2),
        .wr_sel_i (WriteSelect),
        .wr_data_i(WriteData),
        .wr_en_i  (RegWrite),
        .rst_i    (Reset),
        .data_o   (ReadData2)
    );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one instance with write-through forwarding, one
// without, driven in lockstep and checked against a shadow register model.
module tb_register_file;
    import register_file_pkg::*;

    logic        CLK;
    logic        Reset;
    logic [4:0]  ReadSelect1;
    logic [4:0]  ReadSelect2;
    logic [4:0]  WriteSelect;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

    register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_b (
        .CLK(CLK), .Reset(Reset), .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
        .WriteSelect(WriteSelect), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(rd1_b), .ReadData2(rd2_b)
    );

    register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_n (
        .CLK(CLK), .Reset(Reset), .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
        .WriteSelect(WriteSelect), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(rd1_n), .ReadData2(rd2_n)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard state
    logic [63:0] exp_q[$];
    logic [63:0] mdl [32];
    logic        known;
    int          checks;
    int          errors;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wsel;
        logic [63:0] wd;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [4:0] sel, input logic byp,
                                               input logic rst, input logic we,
                                               input logic [4:0] wsel, input logic [63:0] wd);
        if (sel == 5'd31) return 64'h0;
        if (byp && !rst && we && wsel == sel) return wd;
        return mdl[sel];
    endfunction

    // Drive one cycle; expected reads (before the edge) are queued at drive
    // time and compared once the combinational outputs settle.
    task automatic do_cycle(input logic rst, input logic we, input logic [4:0] wsel,
                            input logic [63:0] wd, input logic [4:0] s1, input logic [4:0] s2,
                            input logic use_tab, input logic [63:0] t1, input logic [63:0] t2,
                            output logic [63:0] o1, output logic [63:0] o2);
        @(negedge CLK);
        Reset = rst; RegWrite = we; WriteSelect = wsel; WriteData = wd;
        ReadSelect1 = s1; ReadSelect2 = s2;
        if (known) begin
            exp_q.push_back(use_tab ? t1 : model_read(s1, 1'b1, rst, we, wsel, wd));
            exp_q.push_back(use_tab ? t2 : model_read(s2, 1'b1, rst, we, wsel, wd));
            exp_q.push_back(model_read(s1, 1'b0, rst, we, wsel, wd));
            exp_q.push_back(model_read(s2, 1'b0, rst, we, wsel, wd));
        end
        #2;
        o1 = rd1_b;
        o2 = rd2_b;
        if (known) begin
            check($sformatf("byp_rd1_sel%0d", s1), rd1_b, exp_q.pop_front());
            check($sformatf("byp_rd2_sel%0d", s2), rd2_b, exp_q.pop_front());
            check($sformatf("nobyp_rd1_sel%0d", s1), rd1_n, exp_q.pop_front());
            check($sformatf("nobyp_rd2_sel%0d", s2), rd2_n, exp_q.pop_front());
        end
        @(posedge CLK);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
            known = 1'b1;
        end else if (we && wsel != 5'd31) begin
            mdl[wsel] = wd;
        end
        #1;
    endtask

    logic [63:0] o1, o2;

    initial begin
        checks = 0; errors = 0; known = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
        Reset = 1'b0; RegWrite = 1'b0; WriteSelect = '0; WriteData = '0;
        ReadSelect1 = '0; ReadSelect2 = '0;

        // Expected outputs of the forwarding instance, before each edge.
        vecs[0]  = '{1'b0, 1'b0, 5'd0,  64'h0,                  5'd3,  5'd0,  64'h0,                  64'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  64'h0000_0000_DEAD_BEEF, 5'd5,  5'd6,  64'h0000_0000_DEAD_BEEF, 64'h0};
        vecs[2]  = '{1'b0, 1'b1, 5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 5'd5,  5'd6,  64'h0000_0000_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  64'h0,                  5'd5,  5'd6,  64'h0000_0000_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4]  = '{1'b0, 1'b1, 5'd31, 64'h1234,               5'd31, 5'd31, 64'h0,                  64'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  64'h0,                  5'd31, 5'd5,  64'h0,                  64'h0000_0000_DEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 5'd7,  64'h10,                 5'd7,  5'd6,  64'h10,                 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7]  = '{1'b0, 1'b1, 5'd7,  64'h20,                 5'd7,  5'd7,  64'h20,                 64'h20};
        vecs[8]  = '{1'b0, 1'b0, 5'd7,  64'h99,                 5'd7,  5'd7,  64'h20,                 64'h20};
        vecs[9]  = '{1'b0, 1'b1, 5'd2,  64'h55,                 5'd2,  5'd31, 64'h55,                 64'h0};
        vecs[10] = '{1'b1, 1'b1, 5'd2,  64'hAA,                 5'd2,  5'd2,  64'h55,                 64'h55};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  64'h0,                  5'd2,  5'd7,  64'h0,                  64'h0};
        vecs[12] = '{1'b0, 1'b1, 5'd2,  64'h77,                 5'd2,  5'd2,  64'h77,                 64'h77};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  64'h0,                  5'd2,  5'd5,  64'h77,                 64'h0};

        // First reset edge with a competing write to X3; reads unchecked until it lands.
        do_cycle(1'b1, 1'b1, 5'd3, 64'hFF, 5'd3, 5'd0, 1'b0, 64'h0, 64'h0, o1, o2);

        for (int k = 0; k < 14; k++) begin
            do_cycle(vecs[k].rst, vecs[k].we, vecs[k].wsel, vecs[k].wd, vecs[k].s1, vecs[k].s2,
                     1'b1, vecs[k].e1, vecs[k].e2, o1, o2);
            if (k == 3) check("alu_add", alu_ref(ALU_ADD, o1, o2), 64'h0000_0000_DEAD_BEEE);
        end

        // Fill X1..X30, idle a cycle with a junk write value, then sweep all selects.
        for (int i = 1; i <= 30; i++) begin
            do_cycle(1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101, 5'(i), 5'(i - 1), 1'b0, 64'h0, 64'h0, o1, o2);
        end
        do_cycle(1'b0, 1'b0, 5'd9, 64'hBAD, 5'd9, 5'd31, 1'b0, 64'h0, 64'h0, o1, o2);
        for (int i = 0; i < 32; i++) begin
            do_cycle(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 1'b0, 64'h0, 64'h0, o1, o2);
            check($sformatf("sweep_x%0d", i), o1, (i == 0 || i == 31) ? 64'h0 : 64'(i) * 64'h0101);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
